// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle: two requesters with data, synchronized read pointer in,
// memory write port, full flag, Gray write pointer and occupancy out.
interface fifo_wr_arbiter_if #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned ADDR_SIZE = 4
);
   logic                 req0;
   logic [DATA_SIZE-1:0] data0;
   logic                 gnt0;
   logic                 req1;
   logic [DATA_SIZE-1:0] data1;
   logic                 gnt1;
   logic [ADDR_SIZE:0]   rd_ptr_sync;
   logic                 en;
   logic [ADDR_SIZE-1:0] wr_addr;
   logic [DATA_SIZE-1:0] wr_data;
   logic                 wr_full;
   logic [ADDR_SIZE:0]   wr_ptr;
   logic [ADDR_SIZE:0]   wr_level;

   modport master (
      output req0, data0, req1, data1, rd_ptr_sync,
      input  gnt0, gnt1, en, wr_addr, wr_data, wr_full, wr_ptr, wr_level
   );

   modport slave (
      input  req0, data0, req1, data1, rd_ptr_sync,
      output gnt0, gnt1, en, wr_addr, wr_data, wr_full, wr_ptr, wr_level
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Async-FIFO write side shared by two requesters: round-robin grant in the
// request cycle, binary/Gray write pointer, full flag and occupancy.
module fifo_wr_arbiter #(
   parameter int unsigned DATA_SIZE = 8,
   parameter int unsigned ADDR_SIZE = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   fifo_wr_arbiter_if.slave   bus
);
   localparam int unsigned PW = ADDR_SIZE + 1;

   typedef enum logic {PRIO0 = 1'b0, PRIO1 = 1'b1} prio_t;

   logic [PW-1:0] r_wbin;
   logic [PW-1:0] r_wgray;
   prio_t         r_prio;

   logic [PW-1:0] w_wbin_nxt;
   logic [PW-1:0] w_wgray_nxt;
   logic [PW-1:0] w_rd_bin;
   prio_t         w_prio_nxt;
   logic          w_full;
   logic          w_gnt0;
   logic          w_gnt1;
   logic          w_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wbin  <= '0;
         r_wgray <= '0;
         r_prio  <= PRIO0;
      end else begin
         r_wbin  <= w_wbin_nxt;
         r_wgray <= w_wgray_nxt;
         r_prio  <= w_prio_nxt;
      end
   end

   always_comb begin
      w_rd_bin = '0;
      for (int unsigned i = 0; i < PW; i++) begin
         w_rd_bin[i] = ^(bus.rd_ptr_sync >> i);
      end
   end

   assign w_full = (r_wgray == {~bus.rd_ptr_sync[ADDR_SIZE:ADDR_SIZE-1],
                                 bus.rd_ptr_sync[ADDR_SIZE-2:0]});

   // Grants are gated by rst_n so nothing is accepted while reset is held.
   always_comb begin
      w_gnt0     = 1'b0;
      w_gnt1     = 1'b0;
      w_prio_nxt = r_prio;
      if (rst_n && !w_full) begin
         if (bus.req0 && bus.req1) begin
            if (r_prio == PRIO1) w_gnt1 = 1'b1;
            else                 w_gnt0 = 1'b1;
         end else begin
            w_gnt0 = bus.req0;
            w_gnt1 = bus.req1;
         end
      end
      if (w_gnt0)      w_prio_nxt = PRIO1;
      else if (w_gnt1) w_prio_nxt = PRIO0;
      w_en        = w_gnt0 | w_gnt1;
      w_wbin_nxt  = r_wbin + PW'(w_en);
      w_wgray_nxt = w_wbin_nxt ^ (w_wbin_nxt >> 1);
   end

   assign bus.gnt0     = w_gnt0;
   assign bus.gnt1     = w_gnt1;
   assign bus.en       = w_en;
   assign bus.wr_addr  = r_wbin[ADDR_SIZE-1:0];
   assign bus.wr_data  = w_gnt1 ? bus.data1 : bus.data0;
   assign bus.wr_full  = w_full;
   assign bus.wr_ptr   = r_wgray;
   assign bus.wr_level = r_wbin - w_rd_bin;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (ADDR_SIZE=4, DATA_SIZE=8) with
// hand-computed expectations checked by immediate assertions.
module tb_fifo_wr_arbiter;
   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   fifo_wr_arbiter_if #(.DATA_SIZE(8), .ADDR_SIZE(4)) bus ();

   fifo_wr_arbiter #(.DATA_SIZE(8), .ADDR_SIZE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   logic [4:0] exp_bin;

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      bus.req0 = 1'b1;
      bus.req1 = 1'b0;
      bus.data0 = 8'h00;
      bus.data1 = 8'h00;
      bus.rd_ptr_sync = 5'b00000;

      // reset state, request ignored while in reset
      #2;
      chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
      chk("rst_en", 32'(bus.en), 32'd0);
      chk("rst_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_ptr", 32'(bus.wr_ptr), 32'd0);
      chk("rst_level", 32'(bus.wr_level), 32'd0);
      chk("rst_full", 32'(bus.wr_full), 32'd0);
      bus.req0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // single write from requester 0
      cyc();
      bus.req0 = 1'b1;
      bus.data0 = 8'hA5;
      #1;
      chk("w1_gnt0", 32'(bus.gnt0), 32'd1);
      chk("w1_gnt1", 32'(bus.gnt1), 32'd0);
      chk("w1_en", 32'(bus.en), 32'd1);
      chk("w1_addr", 32'(bus.wr_addr), 32'd0);
      chk("w1_data", 32'(bus.wr_data), 32'hA5);
      cyc();
      bus.req0 = 1'b0;
      #1;
      chk("w1_addr_after", 32'(bus.wr_addr), 32'd1);
      chk("w1_ptr_after", 32'(bus.wr_ptr), 32'b00001);
      chk("w1_level_after", 32'(bus.wr_level), 32'd1);
      chk("w1_idle_en", 32'(bus.en), 32'd0);

      // fresh reset so priority starts at 0, then alternate
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.data0 = 8'h11;
      bus.data1 = 8'h22;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_gnt0", 32'(bus.gnt0), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_gnt1", 32'(bus.gnt1), (i % 2 == 1) ? 32'd1 : 32'd0);
         chk("rr_data", 32'(bus.wr_data), (i % 2 == 0) ? 32'h11 : 32'h22);
         chk("rr_addr", 32'(bus.wr_addr), 32'(i));
         cyc();
      end

      // fill to 16 with both requests held
      for (int i = 4; i < 16; i++) begin
         chk("fill_en", 32'(bus.en), 32'd1);
         cyc();
      end
      chk("full_ptr", 32'(bus.wr_ptr), 32'b11000);
      chk("full_flag", 32'(bus.wr_full), 32'd1);
      chk("full_level", 32'(bus.wr_level), 32'd16);
      chk("full_gnt0", 32'(bus.gnt0), 32'd0);
      chk("full_gnt1", 32'(bus.gnt1), 32'd0);
      chk("full_en", 32'(bus.en), 32'd0);
      cyc();
      chk("full_hold_ptr", 32'(bus.wr_ptr), 32'b11000);

      // one slot freed by the reader
      bus.rd_ptr_sync = 5'b00001;
      #1;
      chk("free_full", 32'(bus.wr_full), 32'd0);
      chk("free_level", 32'(bus.wr_level), 32'd15);
      chk("free_gnt0", 32'(bus.gnt0), 32'd1);
      chk("free_en", 32'(bus.en), 32'd1);
      chk("free_addr", 32'(bus.wr_addr), 32'd0);
      cyc();
      chk("refull_flag", 32'(bus.wr_full), 32'd1);
      chk("refull_en", 32'(bus.en), 32'd0);
      chk("refull_ptr", 32'(bus.wr_ptr), 32'b11001);
      chk("refull_level", 32'(bus.wr_level), 32'd16);

      // 32 writes with the reader one behind: pointer wraps, never full
      bus.req1 = 1'b0;
      bus.rd_ptr_sync = 5'b00000;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      #1;
      exp_bin = 5'd0;
      for (int i = 0; i < 32; i++) begin
         chk("wrap_full", 32'(bus.wr_full), 32'd0);
         chk("wrap_en", 32'(bus.en), 32'd1);
         chk("wrap_addr", 32'(bus.wr_addr), 32'(exp_bin[3:0]));
         cyc();
         exp_bin = exp_bin + 5'd1;
         chk("wrap_ptr", 32'(bus.wr_ptr), 32'(gray(exp_bin)));
         bus.rd_ptr_sync = gray(exp_bin - 5'd1);
         #1;
      end
      chk("wrap_ptr_zero", 32'(bus.wr_ptr), 32'd0);
      chk("wrap_level", 32'(bus.wr_level), 32'd1);

      // async reset between edges mid-write
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      bus.rd_ptr_sync = 5'b00000;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("pre_ar_addr", 32'(bus.wr_addr), 32'd3);
      chk("pre_ar_gnt1", 32'(bus.gnt1), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_en", 32'(bus.en), 32'd0);
      chk("ar_gnt0", 32'(bus.gnt0), 32'd0);
      chk("ar_gnt1", 32'(bus.gnt1), 32'd0);
      chk("ar_addr", 32'(bus.wr_addr), 32'd0);
      chk("ar_ptr", 32'(bus.wr_ptr), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar_prio_gnt0", 32'(bus.gnt0), 32'd1);
      chk("ar_prio_gnt1", 32'(bus.gnt1), 32'd0);
      cyc();
      chk("post_ar_addr", 32'(bus.wr_addr), 32'd1);
      chk("post_ar_gnt1", 32'(bus.gnt1), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 8, width of the write data word SHALL be DATA_SIZE.
REQ-002 Parameter ADDR_SIZE, default 4, memory address width SHALL be ADDR_SIZE; depth SHALL be 2^ADDR_SIZE.
REQ-003 Port clk  input  1  write-domain clock, all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  reset SHALL be asynchronous and active-low.
REQ-005 Port req0  input  1  requester 0 write request, held until granted.
REQ-006 Port data0  input  DATA_SIZE  requester 0 write data.
REQ-007 Port gnt0  output  1  requester 0 accepted this cycle.
REQ-008 Port req1  input  1  requester 1 write request, held until granted.
REQ-009 Port data1  input  DATA_SIZE  requester 1 write data.
REQ-010 Port gnt1  output  1  requester 1 accepted this cycle.
REQ-011 Port rd_ptr_sync  input  ADDR_SIZE+1  Gray-coded read pointer, already synchronized into clk domain.
REQ-012 Port en  output  1  memory write enable.
REQ-013 Port wr_addr  output  ADDR_SIZE  memory write address.
REQ-014 Port wr_data  output  DATA_SIZE  memory write data.
REQ-015 Port wr_full  output  1  FIFO full, also drives memory full input.
REQ-016 Port wr_ptr  output  ADDR_SIZE+1  Gray-coded write pointer for the read-side synchronizer.
REQ-017 Port wr_level  output  ADDR_SIZE+1  write-side occupancy, 0..2^ADDR_SIZE.

Function
REQ-018 State SHALL be: binary write pointer wbin (ADDR_SIZE+1 bits), Gray pointer wgray, one-bit round-robin priority prio.
REQ-019 wr_ptr SHALL equal wgray = wbin ^ (wbin >> 1), registered.
REQ-020 wr_addr SHALL equal wbin[ADDR_SIZE-1:0].
REQ-021 wr_full SHALL be combinational: wgray == {~rd_ptr_sync[ADDR_SIZE:ADDR_SIZE-1], rd_ptr_sync[ADDR_SIZE-2:0]}.
REQ-022 wr_level SHALL be combinational: wbin minus Gray-to-binary(rd_ptr_sync), modulo 2^(ADDR_SIZE+1).
REQ-023 Grant SHALL be combinational, same cycle as request; at most one of gnt0/gnt1 SHALL be high.
REQ-024 If wr_full=1, gnt0=gnt1=en=0 regardless of requests.
REQ-025 If exactly one request and not full, that requester SHALL be granted.
REQ-026 If both request and not full, requester prio SHALL be granted.
REQ-027 On any grant, prio SHALL become the index of the non-granted requester at the next edge; no grant leaves prio unchanged.
REQ-028 en SHALL equal gnt0|gnt1; wr_data SHALL be data1 when gnt1, else data0.
REQ-029 On each edge with en=1, wbin SHALL increment by 1, wrapping 2^(ADDR_SIZE+1)-1 to 0; no other pointer change.
REQ-030 A request SHALL be accepted exactly once per grant cycle; a held req after gnt is a new write.
REQ-031 rd_ptr_sync changes SHALL affect wr_full and wr_level in the same cycle, no added latency.

Reset
REQ-032 rst_n low SHALL immediately force wbin=0, wgray=0, prio=0, hence wr_addr=0, wr_ptr=0.
REQ-033 During reset gnt0, gnt1, en SHALL be 0; wr_full and wr_level follow REQ-021/022 from rd_ptr_sync.
REQ-034 First edge after rst_n deasserts SHALL be a normal operating cycle.

Verification (ADDR_SIZE=4, DATA_SIZE=8, rd_ptr_sync=0 unless stated)
REQ-035 After reset, req0=1 data0=8'hA5 -> gnt0=1 en=1 wr_addr=0 wr_data=8'hA5; next edge wr_addr=1 wr_ptr=5'b00001 wr_level=1.
REQ-036 req0=req1=1 held for 4 cycles -> grants 0,1,0,1; wr_data follows the granted data input.
REQ-037 16 accepted writes -> wr_ptr=5'b11000, wr_full=1, wr_level=16, gnt0=gnt1=en=0 with requests held.
REQ-038 From full, set rd_ptr_sync=5'b00001 -> wr_full=0 same cycle, one grant with wr_addr=0, then wr_full=1 again.
REQ-039 32 writes with rd_ptr_sync tracking one behind -> wbin wraps, wr_ptr returns to 5'b00000, wr_full never asserts.
REQ-040 rst_n pulsed low mid-write between edges -> en, gnt0, gnt1, wr_addr, wr_ptr go to 0 without waiting for clk; prio=0.
